// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) sequencer owning the HI/LO pair.
// Optional: define MULTDIV_FAST_ZERO_EN to short-circuit zero operands straight to FINISH.
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MULT   = 3'd1,
        DIV    = 3'd2,
        FINISH = 3'd3,
        DZERO  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH:0]   acc;       // Booth accumulator, or division partial remainder
    logic [WIDTH-1:0] q;         // Booth multiplier, or dividend magnitude / quotient
    logic [WIDTH-1:0] m;         // multiplicand, or divisor magnitude
    logic             q_m1;
    logic             is_div;
    logic             neg_quot;
    logic             neg_rem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] rem_diff;
    logic             rem_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;
    logic             fast_mult;
    logic             fast_div;

    assign m_ext = {m[WIDTH-1], m};
    assign abs_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign abs_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
    assign quot_final = neg_quot ? (~q + 1'b1) : q;
    assign rem_final  = neg_rem ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

`ifdef MULTDIV_FAST_ZERO_EN
    assign fast_mult = (op_a == '0) || (op_b == '0);
    assign fast_div  = (op_a == '0);
`else
    assign fast_mult = 1'b0;
    assign fast_div  = 1'b0;
`endif

    always_comb begin
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits;
        // one extra bit on the difference gives a clean sign for the restore decision.
        rem_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
        rem_diff = {1'b0, rem_sh} - {2'b00, m};
        rem_neg  = rem_diff[WIDTH+1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            q_m1     <= 1'b0;
            is_div   <= 1'b0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        m      <= op_a;
                        q      <= op_b;
                        q_m1   <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                        is_div <= 1'b0;
                        if (fast_mult) begin
                            q     <= '0;
                            state <= FINISH;
                        end else begin
                            busy  <= 1'b1;
                            state <= MULT;
                        end
                    end else if (start_div) begin
                        if (op_b != '0) begin
                            m        <= abs_b;
                            q        <= abs_a;
                            acc      <= '0;
                            cnt      <= '0;
                            is_div   <= 1'b1;
                            neg_quot <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_rem  <= op_a[WIDTH-1];
                            if (fast_div) begin
                                q     <= '0;
                                state <= FINISH;
                            end else begin
                                busy  <= 1'b1;
                                state <= DIV;
                            end
                        end else begin
                            state <= DZERO;
                        end
                    end
                end
                MULT: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    if (cnt == LAST_STEP) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    acc <= rem_neg ? rem_sh : rem_diff[WIDTH:0];
                    q   <= {q[WIDTH-2:0], ~rem_neg};
                    if (cnt == LAST_STEP) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    if (is_div) begin
                        lo <= quot_final;
                        hi <= rem_final;
                    end else begin
                        hi <= acc[WIDTH-1:0];
                        lo <= q;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                DZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model of HI/LO, flags and latency.
module tb_multdiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    multdiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: signed 64-bit product, C-style truncating division.
    task automatic model_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                            output bit dz, output int lat, output int busy_cycles);
        longint sa, sb, p, qq, rr;
        bit fast;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        fast = 1'b0;
        dz = 1'b0;
`ifdef MULTDIV_FAST_ZERO_EN
        fast = mul ? (a == 0 || b == 0) : (a == 0 && b != 0);
`endif
        if (mul) begin
            p = sa * sb;
            model_hi = p[63:32];
            model_lo = p[31:0];
        end else if (b == 0) begin
            dz = 1'b1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            model_lo = qq[31:0];
            model_hi = rr[31:0];
        end
        lat = (dz || fast) ? 1 : 33;
        busy_cycles = (dz || fast) ? 0 : 32;
    endtask

    task automatic run_op(input string tag, input bit mul, input bit dv,
                          input logic [31:0] a, input logic [31:0] b, input bit inject);
        int k, bc, exp_lat, exp_bc;
        bit exp_dz;
        @(negedge clk);
        start_mult = mul;
        start_div = dv;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        model_op(mul, a, b, exp_dz, exp_lat, exp_bc);
        k = 0;
        bc = 0;
        while (!done && k < 100) begin
            bc += int'(busy);
            if (inject && k == 5) begin
                start_div = 1'b1;
                op_a = 32'd100;
                op_b = 32'd7;
            end else begin
                start_div = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start_div = 1'b0;
        $display("op %s mul=%0d div=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", tag, mul, dv, a, b,
                 hi, lo, div_zero, k);
        check({tag, ".latency"}, 32'(k), 32'(exp_lat));
        check({tag, ".hi"}, hi, model_hi);
        check({tag, ".lo"}, lo, model_lo);
        check({tag, ".div_zero"}, 32'(div_zero), 32'(exp_dz));
        check({tag, ".busy_cycles"}, 32'(bc), 32'(exp_bc));
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, {30'd0, done, div_zero}, 32'd0);
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.flags", {30'd0, done, div_zero}, 32'd0);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_neg7x6", 1, 0, 32'hFFFFFFF9, 32'd6, 0);
        check("mul_neg7x6.hi_const", hi, 32'hFFFFFFFF);
        check("mul_neg7x6.lo_const", lo, 32'hFFFFFFD6);
        run_op("mul_min_min", 1, 0, 32'h80000000, 32'h80000000, 0);
        check("mul_min_min.hi_const", hi, 32'h40000000);
        run_op("mul_max_x2", 1, 0, 32'h7FFFFFFF, 32'd2, 0);
        run_op("div_m17_5", 0, 1, 32'hFFFFFFEF, 32'd5, 0);
        check("div_m17_5.lo_const", lo, 32'hFFFFFFFD);
        check("div_m17_5.hi_const", hi, 32'hFFFFFFFE);
        run_op("div_17_m5", 0, 1, 32'd17, 32'hFFFFFFFB, 0);
        run_op("div_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_min_m1.lo_const", lo, 32'h80000000);
        run_op("preload", 1, 0, 32'd6, 32'h2AAAAAAB, 0);
        check("preload.hi_const", hi, 32'd1);
        check("preload.lo_const", lo, 32'd2);
        run_op("div_by_zero", 0, 1, 32'd9, 32'd0, 0);
        run_op("both_starts", 1, 1, 32'd5, 32'd3, 0);
        run_op("inject_div", 1, 0, 32'h00012345, 32'hFFFF0001, 1);
        run_op("zero_mult", 1, 0, 32'd0, 32'd12345, 0);
        run_op("zero_div", 0, 1, 32'd0, 32'd77, 0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start_mult = 1'b1;
        op_a = 32'h00001234;
        op_b = 32'h00005678;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_hi = '0;
        model_lo = '0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.hi", hi, model_hi);
        check("midrst.lo", lo, model_lo);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst.idle", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            bit mul, dv;
            logic [31:0] a, b;
            mul = $urandom_range(0, 2) == 0;
            dv  = !mul || ($urandom_range(0, 3) == 0);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                4: a = -32'($urandom_range(0, 200));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), mul, dv, a, b, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
